// File: rtl/ulpi_reg_access.sv
// rtl/ulpi_reg_access.sv - ULPI link-side register read/write engine (TXCMD handshake, one request at a time)
module ulpi_reg_access #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_error,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_TXCMD, S_REISSUE, S_WDATA, S_STOP,
    S_RD_TURN, S_RD_DATA, S_RD_END, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          write_q, write_d;
  logic [5:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          oe_q, oe_d;
  logic [7:0]    dout_q, dout_d;
  logic          stp_q, stp_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_error_q, rsp_error_d;
  logic          accept, waiting, err;

  assign req_ready     = (state_q == S_IDLE) && !ulpi_dir;
  assign accept        = req_valid && req_ready;
  // The PHY owns the bus the moment DIR rises, so drive is cut without waiting for a clock.
  assign ulpi_data_oe  = oe_q && !ulpi_dir;
  assign ulpi_data_out = ulpi_data_oe ? dout_q : 8'h00;
  assign ulpi_stp      = stp_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_error     = rsp_error_q;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    waiting     = 1'b0;
    err         = 1'b0;

    case (state_q)
      S_IDLE: if (accept) begin
        write_d = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        state_d = S_TXCMD;
      end
      S_TXCMD: begin
        waiting = 1'b1;
        if (ulpi_dir && !ulpi_nxt)      state_d = S_REISSUE;
        else if (!ulpi_dir && ulpi_nxt) state_d = write_q ? S_WDATA : S_RD_TURN;
      end
      S_REISSUE: begin
        waiting = 1'b1;
        if (!ulpi_dir) state_d = S_TXCMD;
      end
      S_WDATA: begin
        waiting = 1'b1;
        if (ulpi_dir)      err = 1'b1;
        else if (ulpi_nxt) state_d = S_STOP;
      end
      S_STOP: state_d = S_DONE;
      S_RD_TURN: begin
        waiting = 1'b1;
        if (ulpi_dir) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (ulpi_dir && !ulpi_nxt) begin
          rd_data_d = ulpi_data_in;
          state_d   = S_RD_END;
        end else begin
          err = 1'b1;
        end
      end
      S_RD_END: begin
        waiting = 1'b1;
        if (!ulpi_dir) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Terminal count is checked one cycle early so the abort lands exactly TIMEOUT_CYCLES after entry.
    if (waiting && (state_d == state_q) && !err) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) err = 1'b1;
      else                                  cnt_d = cnt_q + CW'(1);
    end

    if (err) state_d = S_DONE;
    if (state_d != state_q) cnt_d = '0;

    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = err;
      rsp_data_d  = (err || write_q) ? 8'h00 : rd_data_q;
    end

    oe_d   = 1'b0;
    dout_d = 8'h00;
    stp_d  = 1'b0;
    case (state_d)
      S_TXCMD: begin oe_d = 1'b1; dout_d = {1'b1, !write_d, addr_d}; end
      S_WDATA: begin oe_d = 1'b1; dout_d = wdata_d; end
      S_STOP:  begin oe_d = 1'b1; stp_d  = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= 6'h00;
      wdata_q     <= 8'h00;
      rd_data_q   <= 8'h00;
      cnt_q       <= '0;
      oe_q        <= 1'b0;
      dout_q      <= 8'h00;
      stp_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      cnt_q       <= cnt_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      stp_q       <= stp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end
endmodule

// File: tb/tb_ulpi_reg_access.sv
// tb/tb_ulpi_reg_access.sv - directed bench for ulpi_reg_access with response scoreboard and bus rules monitor
module tb_ulpi_reg_access;
  localparam int TMO = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_error;
  logic [7:0] rsp_data;
  logic       ulpi_dir, ulpi_nxt, ulpi_stp, ulpi_data_oe;
  logic [7:0] ulpi_data_in, ulpi_data_out;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  logic       prev_rv = 1'b0;

  ulpi_reg_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_stp(ulpi_stp),
    .ulpi_data_in(ulpi_data_in), .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Bus rules and the response scoreboard, evaluated every cycle.
  always @(negedge clk) begin
    logic [8:0] e;
    #2;
    if (ulpi_dir) chk("oe_off_while_dir", ulpi_data_oe, 0);
    if (!ulpi_data_oe) chk("bus_idle_value", ulpi_data_out, 0);
    if (rsp_valid) begin
      chk("no_ready_with_rsp", req_ready, 0);
      chk("rsp_single_cycle", prev_rv, 0);
      chk("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_error_model", rsp_error, e[8]);
        chk("rsp_data_model", rsp_data, e[7:0]);
      end
    end
    prev_rv = rsp_valid;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_req(input logic w, input logic [5:0] a, input logic [7:0] d, input logic keep);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    #1;
    while (!req_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("req_accepted", req_ready, 1);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  // Entered in the first TXCMD cycle; ends in the rsp_valid cycle.
  task automatic phy_read(input logic [7:0] d);
    ulpi_nxt = 1'b1;
    step();
    chk("rd_turn_oe", ulpi_data_oe, 0);
    ulpi_nxt = 1'b0; ulpi_dir = 1'b1;
    step();
    ulpi_data_in = d;
    step();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
    step();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data, d);
    chk("rd_rsp_error", rsp_error, 0);
  endtask

  task automatic phy_write(input logic [7:0] cmd, input logic [7:0] wd);
    chk("wr_cmd", ulpi_data_out, cmd);
    step();
    chk("wr_cmd_hold", ulpi_data_out, cmd);
    ulpi_nxt = 1'b1;
    step();
    chk("wr_data", ulpi_data_out, wd);
    chk("wr_data_oe", ulpi_data_oe, 1);
    step();
    chk("wr_stp", ulpi_stp, 1);
    chk("wr_stp_data", ulpi_data_out, 0);
    chk("wr_stp_oe", ulpi_data_oe, 1);
    ulpi_nxt = 1'b0;
    step();
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_stp_gone", ulpi_stp, 0);
    chk("wr_rsp_error", rsp_error, 0);
    chk("wr_rsp_data", rsp_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 6'h00; req_wdata = 8'h00;
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00;
    step();
    chk("rst_oe", ulpi_data_oe, 0);
    chk("rst_stp", ulpi_stp, 0);
    chk("rst_dout", ulpi_data_out, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_error", rsp_error, 0);
    step();
    reset = 1'b1;
    step();
    chk("idle_ready", req_ready, 1);

    // 1: read 0x00 returns 0x24
    exp_q.push_back({1'b0, 8'h24});
    send_req(1'b0, 6'h00, 8'h00, 1'b0);
    chk("t1_cmd", ulpi_data_out, 8'hC0);
    chk("t1_cmd_oe", ulpi_data_oe, 1);
    phy_read(8'h24);
    step();
    chk("t1_rsp_drop", rsp_valid, 0);
    chk("t1_rsp_held", rsp_data, 8'h24);
    chk("t1_ready_back", req_ready, 1);

    // 2: write 0x0A <- 0x00
    exp_q.push_back({1'b0, 8'h00});
    send_req(1'b1, 6'h0A, 8'h00, 1'b0);
    phy_write(8'h8A, 8'h00);
    step();

    // 3: RX CMD preempts TXCMD 0xC1, then reissue
    exp_q.push_back({1'b0, 8'h04});
    send_req(1'b0, 6'h01, 8'h00, 1'b0);
    chk("t3_cmd", ulpi_data_out, 8'hC1);
    ulpi_dir = 1'b1;
    #1;
    chk("t3_oe_same_cycle", ulpi_data_oe, 0);
    step(); step(); step();
    ulpi_dir = 1'b0;
    step();
    chk("t3_reissue_cmd", ulpi_data_out, 8'hC1);
    chk("t3_reissue_oe", ulpi_data_oe, 1);
    phy_read(8'h04);
    step();

    // 4: nxt never comes -> timeout
    exp_q.push_back({1'b1, 8'h00});
    send_req(1'b0, 6'h10, 8'h00, 1'b0);
    chk("t4_cmd", ulpi_data_out, 8'hD0);
    c = 0;
    while (!rsp_valid && c < TMO + 20) begin
      step(); c++;
    end
    chk("t4_timeout_cycles", c, TMO);
    chk("t4_rsp_error", rsp_error, 1);
    chk("t4_rsp_data", rsp_data, 0);
    step();
    chk("t4_ready_next", req_ready, 1);

    // 5: reset asserted mid-WDATA
    send_req(1'b1, 6'h05, 8'h77, 1'b0);
    ulpi_nxt = 1'b1;
    step();
    chk("t5_wdata", ulpi_data_out, 8'h77);
    #3 reset = 1'b0;
    #1;
    chk("t5_rst_oe", ulpi_data_oe, 0);
    chk("t5_rst_stp", ulpi_stp, 0);
    chk("t5_rst_rsp_valid", rsp_valid, 0);
    chk("t5_rst_dout", ulpi_data_out, 0);
    ulpi_nxt = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    exp_q.push_back({1'b0, 8'h04});
    send_req(1'b0, 6'h02, 8'h00, 1'b0);
    chk("t5_cmd", ulpi_data_out, 8'hC2);
    phy_read(8'h04);
    step();

    // 6: back-to-back read then write with req_valid held
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, 8'h00});
    send_req(1'b0, 6'h03, 8'h00, 1'b1);
    chk("t6_rd_cmd", ulpi_data_out, 8'hC3);
    req_write = 1'b1; req_addr = 6'h07; req_wdata = 8'h3C;
    phy_read(8'h5A);
    step();
    chk("t6_ready_after_rsp", req_ready, 1);
    step();
    req_valid = 1'b0;
    phy_write(8'h87, 8'h3C);
    step(); step();

    chk("rsp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
